// File: rtl/serial_adder_nbit.sv
// Purpose : digit-serial unsigned adder, sum = (a + b + cin) mod 2^WIDTH, DIGIT bits per clock, LSB digit first.
// Latency : out_valid rises NDIG = WIDTH/DIGIT cycles after the acceptance edge; back-to-back rate is one result per NDIG+1 cycles.
// Backpr. : the result is held in DONE until out_ready; in_ready stays low while an unconsumed result is pending.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake for a, b, cin (WIDTH, WIDTH, 1 bits)
//   out_valid / out_ready result handshake for sum (WIDTH) and cout (1)
//   busy                  high while digits are being processed
//
// Optional build macro SERIAL_ADDER_OVF_EN adds output ovf: registered two's-complement
// overflow flag of the latched operands, updated together with sum.
module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    // Refuse to build a configuration that cannot be split into whole digits.
    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
            $error("serial_adder_nbit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand shift registers: the digit being added always sits in the low DIGIT bits.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Partial sum fills from the MSB end so that after NDIG shifts digit 0 lands in the LSBs.
    logic [WIDTH-1:0] psum_q, psum_d;
    // Presented result; only ever loaded with a completed sum.
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

`ifdef SERIAL_ADDER_OVF_EN
    // Operand sign bits are kept separately because a_q/b_q are shifted away during RUN.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic             accept;
    logic             last_dig;
    logic [DIGIT:0]   dig_sum;
    logic [WIDTH-1:0] psum_shift;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_dig) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Consuming the result and taking new operands can share one edge.
                if (out_ready) begin
                    state_d = in_valid ? ST_RUN : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            // in_ready is gated by rst_n so nothing is offered while reset is held.
            ST_IDLE: in_ready = rst_n;
            ST_RUN:  busy     = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = rst_n & out_ready;
            end
            default: ;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

    // ------------------------------------------------------------------
    // Digit adder and partial-sum shift
    // ------------------------------------------------------------------
    always_comb begin
        dig_sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // Shift-and-OR form also covers NDIG == 1, where the new digit is the whole word.
        psum_shift = (psum_q >> DIGIT) | (WIDTH'(dig_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
            psum_d  = '0;
`ifdef SERIAL_ADDER_OVF_EN
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
`endif
        end else if (state_q == ST_RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dig_sum[DIGIT];
            psum_d  = psum_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_dig) begin
                // Only the completed word reaches the visible result registers.
                sum_d  = psum_shift;
                cout_d = dig_sum[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                ovf_d  = (a_msb_q == b_msb_q) && (psum_shift[WIDTH-1] != a_msb_q);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Purpose : directed checks of serial_adder_nbit in three configurations (8/1, 16/4, 8/2).
// Latency : measures cycles from acceptance edge to out_valid against NDIG.
// Backpr. : exercises DONE stall with out_ready low and back-to-back consume+accept.
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // WIDTH=8, DIGIT=1
    logic        d1_in_valid, d1_in_ready, d1_cin, d1_out_valid, d1_out_ready, d1_cout, d1_busy;
    logic [7:0]  d1_a, d1_b, d1_sum;
    // WIDTH=16, DIGIT=4
    logic        d2_in_valid, d2_in_ready, d2_cin, d2_out_valid, d2_out_ready, d2_cout, d2_busy;
    logic [15:0] d2_a, d2_b, d2_sum;
    // WIDTH=8, DIGIT=2
    logic        d3_in_valid, d3_in_ready, d3_cin, d3_out_valid, d3_out_ready, d3_cout, d3_busy;
    logic [7:0]  d3_a, d3_b, d3_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic        d1_ovf, d2_ovf, d3_ovf;
`endif

    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .cin(d1_cin),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .sum(d1_sum), .cout(d1_cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(d1_ovf),
`endif
        .busy(d1_busy)
    );

    serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .a(d2_a), .b(d2_b), .cin(d2_cin),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .sum(d2_sum), .cout(d2_cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(d2_ovf),
`endif
        .busy(d2_busy)
    );

    serial_adder_nbit #(.WIDTH(8), .DIGIT(2)) u_d3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .a(d3_a), .b(d3_b), .cin(d3_cin),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .sum(d3_sum), .cout(d3_cout),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(d3_ovf),
`endif
        .busy(d3_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // Each run task: present operands for one edge (caller guarantees in_ready), scramble the
    // inputs afterwards, then count edges until out_valid. k=0 is the sample right after acceptance.
    task automatic run1(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat, output int busy_n, output logic moved);
        logic [7:0] s0;
        d1_a = av; d1_b = bv; d1_cin = cv; d1_in_valid = 1'b1;
        @(posedge clk); #1;
        d1_in_valid = 1'b0; d1_a = ~av; d1_b = ~bv; d1_cin = ~cv;
        s0 = d1_sum; lat = -1; busy_n = 0; moved = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (d1_out_valid) begin lat = k; break; end
            if (d1_busy) busy_n++;
            if (d1_sum !== s0) moved = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run2(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        output int lat, output int busy_n, output logic moved);
        logic [15:0] s0;
        d2_a = av; d2_b = bv; d2_cin = cv; d2_in_valid = 1'b1;
        @(posedge clk); #1;
        d2_in_valid = 1'b0; d2_a = ~av; d2_b = ~bv; d2_cin = ~cv;
        s0 = d2_sum; lat = -1; busy_n = 0; moved = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (d2_out_valid) begin lat = k; break; end
            if (d2_busy) busy_n++;
            if (d2_sum !== s0) moved = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run3(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        output int lat, output int busy_n, output logic moved);
        logic [7:0] s0;
        d3_a = av; d3_b = bv; d3_cin = cv; d3_in_valid = 1'b1;
        @(posedge clk); #1;
        d3_in_valid = 1'b0; d3_a = ~av; d3_b = ~bv; d3_cin = ~cv;
        s0 = d3_sum; lat = -1; busy_n = 0; moved = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (d3_out_valid) begin lat = k; break; end
            if (d3_busy) busy_n++;
            if (d3_sum !== s0) moved = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   busy_n;
        int   vld_n;
        logic moved;

        rst_n = 1'b0;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_cin = 1'b0; d1_out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_a = '0; d2_b = '0; d2_cin = 1'b0; d2_out_ready = 1'b0;
        d3_in_valid = 1'b0; d3_a = '0; d3_b = '0; d3_cin = 1'b0; d3_out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(d1_in_ready),  32'd0);
        chk("rst_out_valid", 32'(d1_out_valid), 32'd0);
        chk("rst_sum",       32'(d1_sum),       32'h0);
        chk("rst_cout",      32'(d1_cout),      32'd0);
        chk("rst_busy",      32'(d1_busy),      32'd0);
        chk("rst_in_ready16", 32'(d2_in_ready), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf",       32'(d1_ovf),       32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(d1_in_ready), 32'd1);
        @(posedge clk); #1;

        // ---------------- A: 8/1, 0x69 + 0xDA ----------------
        run1(8'h69, 8'hDA, 1'b0, lat, busy_n, moved);
        chk("A_latency",    32'(lat),          32'd8);
        chk("A_busy_cyc",   32'(busy_n),       32'd8);
        chk("A_no_partial", 32'(moved),        32'd0);
        chk("A_sum",        32'(d1_sum),       32'h43);
        chk("A_cout",       32'(d1_cout),      32'd1);
        chk("A_busy_done",  32'(d1_busy),      32'd0);
        chk("A_rdy_done",   32'(d1_in_ready),  32'd0);
        d1_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("A_vld_drop",   32'(d1_out_valid), 32'd0);
        chk("A_idle_rdy",   32'(d1_in_ready),  32'd1);
        chk("A_sum_hold",   32'(d1_sum),       32'h43);

        // ---------------- B: 8/1, 0xAF + 0x39 + 1, stall ----------------
        d1_out_ready = 1'b0;
        run1(8'hAF, 8'h39, 1'b1, lat, busy_n, moved);
        chk("B_latency", 32'(lat),     32'd8);
        chk("B_sum",     32'(d1_sum),  32'hE9);
        chk("B_cout",    32'(d1_cout), 32'd0);
        // New operands offered during the stall must be ignored.
        d1_in_valid = 1'b1; d1_a = 8'h12; d1_b = 8'h34; d1_cin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("B_stall_vld",  32'(d1_out_valid), 32'd1);
            chk("B_stall_sum",  32'(d1_sum),       32'hE9);
            chk("B_stall_cout", 32'(d1_cout),      32'd0);
            chk("B_stall_rdy",  32'(d1_in_ready),  32'd0);
        end
        d1_in_valid = 1'b0;
        d1_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("B_vld_drop", 32'(d1_out_valid), 32'd0);
        chk("B_not_run",  32'(d1_busy),      32'd0);

        // ---------------- C: 16/4, 0xFFFF + 0x0000 + 1 ----------------
        run2(16'hFFFF, 16'h0000, 1'b1, lat, busy_n, moved);
        chk("C_latency",  32'(lat),     32'd4);
        chk("C_busy_cyc", 32'(busy_n),  32'd4);
        chk("C_sum",      32'(d2_sum),  32'h0000);
        chk("C_cout",     32'(d2_cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        chk("C_ovf",      32'(d2_ovf),  32'd0);
`endif
        d2_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("C_vld_drop", 32'(d2_out_valid), 32'd0);

        // ---------------- D: 8/2, 0x55 + 0x33 + 1, then back-to-back 0x01 + 0x01 ----------------
        run3(8'h55, 8'h33, 1'b1, lat, busy_n, moved);
        chk("D1_latency",    32'(lat),     32'd4);
        chk("D1_no_partial", 32'(moved),   32'd0);
        chk("D1_sum",        32'(d3_sum),  32'h89);
        chk("D1_cout",       32'(d3_cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("D1_ovf",        32'(d3_ovf),  32'd1);
`endif
        d3_out_ready = 1'b1;
        d3_in_valid = 1'b1; d3_a = 8'h01; d3_b = 8'h01; d3_cin = 1'b0;
        #1;
        chk("D_b2b_rdy", 32'(d3_in_ready), 32'd1);
        @(posedge clk); #1;
        d3_in_valid = 1'b0; d3_out_ready = 1'b0; d3_a = 8'hFF; d3_b = 8'hFF; d3_cin = 1'b1;
        chk("D_consumed", 32'(d3_out_valid), 32'd0);
        chk("D_direct_run", 32'(d3_busy),    32'd1);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (d3_out_valid) begin lat = k; break; end
            @(posedge clk); #1;
        end
        chk("D2_latency", 32'(lat),     32'd4);
        chk("D2_sum",     32'(d3_sum),  32'h02);
        chk("D2_cout",    32'(d3_cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("D2_ovf",     32'(d3_ovf),  32'd0);
`endif
        d3_out_ready = 1'b1;
        @(posedge clk); #1;

        // ---------------- E: 8/1 reset while counter = 3 ----------------
        d1_a = 8'hFF; d1_b = 8'hFF; d1_cin = 1'b1; d1_in_valid = 1'b1;
        @(posedge clk); #1;
        d1_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("E_running", 32'(d1_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("E_rst_vld",  32'(d1_out_valid), 32'd0);
        chk("E_rst_busy", 32'(d1_busy),      32'd0);
        chk("E_rst_rdy",  32'(d1_in_ready),  32'd0);
        chk("E_rst_sum",  32'(d1_sum),       32'h0);
        chk("E_rst_cout", 32'(d1_cout),      32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("E_idle_rdy", 32'(d1_in_ready), 32'd1);
        vld_n = 0; busy_n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (d1_out_valid) vld_n++;
            if (d1_busy) busy_n++;
        end
        chk("E_no_result", 32'(vld_n),  32'd0);
        chk("E_no_run",    32'(busy_n), 32'd0);

`ifdef SERIAL_ADDER_OVF_EN
        // ---------------- F: 8/1 signed overflow flag ----------------
        d1_out_ready = 1'b1;
        run1(8'h7F, 8'h01, 1'b0, lat, busy_n, moved);
        chk("F1_sum",  32'(d1_sum),  32'h80);
        chk("F1_cout", 32'(d1_cout), 32'd0);
        chk("F1_ovf",  32'(d1_ovf),  32'd1);
        @(posedge clk); #1;
        run1(8'hFF, 8'h01, 1'b0, lat, busy_n, moved);
        chk("F2_sum",  32'(d1_sum),  32'h00);
        chk("F2_cout", 32'(d1_cout), 32'd1);
        chk("F2_ovf",  32'(d1_ovf),  32'd0);
        @(posedge clk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
Parametrised digit-serial adder, successor to the fixed 8-bit combinational full adder. Computes A + B + Cin over WIDTH bits, DIGIT bits per clock, LSB digit first. Operands enter and results leave through a valid/ready handshake on each side. Intended for area-constrained datapaths where a full-width carry chain is too costly.

Parameters:
WIDTH, 8, operand and sum width in bits; must be ≥ 2.
DIGIT, 1, bits added per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails. NDIG = WIDTH/DIGIT.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry in.
out_valid  output  1  sum/cout are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered (a+b+cin) mod 2^WIDTH.
cout  output  1  registered carry out of bit WIDTH-1.
busy  output  1  high in RUN state.

Behaviour:
- Reset (async assert, rst_n=0): state=IDLE; in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0, sum=0, cout=0, busy=0, digit counter=0, internal operand/partial registers=0. Reset mid-RUN or DONE aborts: the pending result is discarded and never presented.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Acceptance = in_valid && in_ready at a rising edge.
- IDLE: on acceptance, latch a, b, cin; set counter=0; go to RUN.
- RUN: each cycle, add digit[counter] of A and B plus the carry register over DIGIT bits. Write the DIGIT-bit result into the partial-sum shift register (shifted in from the MSB end). Update the carry. Increment counter.
- RUN exit: on the edge that processes digit NDIG-1, load sum from the completed partial register and cout from the final carry, then go to DONE.
- Latency: out_valid rises exactly NDIG cycles after the acceptance edge (WIDTH=8, DIGIT=1: 8 cycles; DIGIT=8: 1 cycle).
- DONE: out_valid=1. sum and cout hold stable until out_valid && out_ready.
- DONE with out_ready=1 and no in_valid: go to IDLE; out_valid drops next cycle.
- DONE with out_ready=1 and in_valid=1: result consumed and new operands accepted on the same edge; go directly to RUN. Back-to-back throughput is one result per NDIG+1 cycles.
- DONE with out_ready=0: stall indefinitely; in_ready=0; new in_valid is ignored.
- in_valid outside acceptance: no effect; inputs a, b, cin may change freely.
- sum/cout change only on the RUN→DONE edge or at reset. They never show partial values.
- Arithmetic: unsigned. The carry register is 1 bit. The per-digit adder is DIGIT+1 bits wide.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit, registered). It is the two's-complement overflow flag: (a[WIDTH-1]==b[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]), computed from the latched operands. It is loaded on the RUN→DONE edge, reset to 0, and held with sum.
- Undefined: port ovf is absent and no related logic exists. All other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x69, b=0xDA, cin=0 → after 8 cycles out_valid=1, sum=0x43, cout=1.
- WIDTH=8, DIGIT=1: a=0xAF, b=0x39, cin=1 → sum=0xE9, cout=0. Hold out_ready=0 for 5 cycles: out_valid, sum and cout stay stable, in_ready=0.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0000, cin=1 → out_valid exactly 4 cycles after acceptance, sum=0x0000, cout=1.
- Back-to-back, WIDTH=8, DIGIT=2: in DONE, assert out_ready=1 and in_valid=1 with a=0x01, b=0x01, cin=0. The first result is consumed, RUN restarts with no IDLE cycle, and sum=0x02 appears 4 cycles later.
- Reset mid-RUN: pulse rst_n=0 at counter=3. All outputs go to 0 immediately (async), state=IDLE, and the aborted result is never presented.
- With SERIAL_ADDER_OVF_EN, WIDTH=8: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0.
